// File: rtl/cpu_clk_sched_pkg.sv
// Shared encodings for the CPU clock scheduler: operating modes, scheduler
// states and the tick-bit clamp helper.
package cpu_clk_sched_pkg;

   localparam logic [1:0] MODE_HALT = 2'b00;
   localparam logic [1:0] MODE_RUN  = 2'b01;
   localparam logic [1:0] MODE_STEP = 2'b10;

   typedef enum logic [1:0] {
      ST_HALT      = 2'd0,
      ST_RUN       = 2'd1,
      ST_STEP_WAIT = 2'd2
   } sched_state_t;

   // Highest prescaler bit that must be ones for a tick; 11 and 00 both halt.
   function automatic int unsigned tick_bit(input logic [4:0] sel, input int unsigned max_bit);
      return ({27'd0, sel} > max_bit) ? max_bit : {27'd0, sel};
   endfunction

   function automatic logic is_halt_mode(input logic [1:0] m);
      return !(m == MODE_RUN || m == MODE_STEP);
   endfunction

endpackage

// File: rtl/cpu_clk_sched_btn_edge_sync.sv
// Two-flop synchronizer for the raw step button followed by a registered
// rising-edge detector; the pulse lands 3 cycles after the button rises.
module btn_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic pulse
);

   logic sync1, sync2, prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
         pulse <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         prev  <= sync2;
         pulse <= sync2 & ~prev;
      end
   end

endmodule

// File: rtl/cpu_clk_sched.sv
// CPU clock-enable scheduler: free-running prescaler, HALT/RUN/STEP FSM and
// VGA pixel enable. Define CPU_CYCLE_COUNT_EN to add the cycle_count output.
import cpu_clk_sched_pkg::*;

module cpu_clk_sched #(
   parameter int CNT_W        = 24,
   parameter int PIX_DIV_LOG2 = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] mode,
   input  logic [4:0] div_sel,
   input  logic       step_btn,
   input  logic       halt_req,
   output logic       cpu_en,
   output logic       pix_en,
   output logic       running
`ifdef CPU_CYCLE_COUNT_EN
   ,output logic [31:0] cycle_count
`endif
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] tick_mask;
   int unsigned      k;
   logic             tick;
   logic             step_pulse;
   logic             cpu_en_raw;
   sched_state_t     state, state_nxt;

   always_ff @(posedge clk) begin
      if (reset) cnt <= '0;
      else       cnt <= cnt + CNT_W'(1);
   end

   // Tick when cnt[k:0] are all ones; a shift of CNT_W leaves the mask full.
   always_comb begin
      k         = tick_bit(div_sel, CNT_W - 1);
      tick_mask = ~({CNT_W{1'b1}} << (k + 1));
      tick      = &(cnt | ~tick_mask);
   end

   generate
      if (PIX_DIV_LOG2 > 0) begin : g_pix
         assign pix_en = ~reset & (&cnt[PIX_DIV_LOG2-1:0]);
      end else begin : g_pix_every
         assign pix_en = ~reset;
      end
   endgenerate

   btn_edge_sync u_btn (
      .clk   (clk),
      .reset (reset),
      .btn   (step_btn),
      .pulse (step_pulse)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_HALT;
      else       state <= state_nxt;
   end

   // Presses are only acted on in HALT, so ones seen in RUN/STEP_WAIT vanish.
   always_comb begin
      state_nxt  = state;
      cpu_en_raw = 1'b0;
      case (state)
         ST_HALT: begin
            if (mode == MODE_RUN && !halt_req)
               state_nxt = ST_RUN;
            else if (mode == MODE_STEP && step_pulse)
               state_nxt = ST_STEP_WAIT;
         end
         ST_RUN: begin
            if (mode != MODE_RUN || halt_req)
               state_nxt = ST_HALT;
            else
               cpu_en_raw = tick;
         end
         ST_STEP_WAIT: begin
            if (is_halt_mode(mode)) begin
               state_nxt = ST_HALT;
            end else begin
               cpu_en_raw = tick;
               if (tick) state_nxt = ST_HALT;
            end
         end
         default: state_nxt = ST_HALT;
      endcase
   end

   assign cpu_en  = cpu_en_raw & ~reset;
   assign running = (state == ST_RUN) & ~reset;

`ifdef CPU_CYCLE_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset)       cycle_count <= '0;
      else if (cpu_en) cycle_count <= cycle_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_cpu_clk_sched.sv
// Bench for cpu_clk_sched: a cycle-level model checks every cycle, directed
// windows pin hand-computed counts. A second 8-bit instance exposes clamping.
module tb_cpu_clk_sched;

   localparam int PIX = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] mode = 2'b00;
   logic [4:0] div_sel = 5'd0;
   logic       step_btn = 1'b0;
   logic       halt_req = 1'b0;
   logic       cpu_en, pix_en, running;
   logic       cpu_en_s, pix_en_s, running_s;
`ifdef CPU_CYCLE_COUNT_EN
   logic [31:0] cycle_count, cycle_count_s;
`endif

   always #5 clk = ~clk;

   cpu_clk_sched #(.CNT_W(24), .PIX_DIV_LOG2(PIX)) dut (
      .clk(clk), .reset(reset), .mode(mode), .div_sel(div_sel),
      .step_btn(step_btn), .halt_req(halt_req),
      .cpu_en(cpu_en), .pix_en(pix_en), .running(running)
`ifdef CPU_CYCLE_COUNT_EN
      , .cycle_count(cycle_count)
`endif
   );

   cpu_clk_sched #(.CNT_W(8), .PIX_DIV_LOG2(PIX)) dut_s (
      .clk(clk), .reset(reset), .mode(mode), .div_sel(div_sel),
      .step_btn(step_btn), .halt_req(halt_req),
      .cpu_en(cpu_en_s), .pix_en(pix_en_s), .running(running_s)
`ifdef CPU_CYCLE_COUNT_EN
      , .cycle_count(cycle_count_s)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: cycles since reset, per-instance scheduler state, button history.
   longint mt = 0;
   int     mst[2] = '{0, 0};
   bit     bh[4]  = '{0, 0, 0, 0};
   int     mcc[2] = '{0, 0};
   int     cw[2]  = '{24, 8};

   function automatic bit m_tick(input longint t, input logic [4:0] d, input int w);
      int kk;
      kk = (int'(d) > w - 1) ? w - 1 : int'(d);
      return ((t + 1) % (longint'(1) << (kk + 1))) == 0;
   endfunction

   always @(negedge clk) begin
      bit en[2];
      bit pulse, hm, pix, tk;
      int nxt;
      int a_en, a_run, a_pix, a_cc;
      for (int j = 0; j < 2; j++) begin
         a_en  = (j == 0) ? int'(cpu_en)  : int'(cpu_en_s);
         a_run = (j == 0) ? int'(running) : int'(running_s);
         a_pix = (j == 0) ? int'(pix_en)  : int'(pix_en_s);
`ifdef CPU_CYCLE_COUNT_EN
         a_cc  = (j == 0) ? int'(cycle_count) : int'(cycle_count_s);
`else
         a_cc  = 0;
`endif
         if (reset) begin
            chk($sformatf("rst_cpu_en%0d", j), a_en, 0);
            chk($sformatf("rst_running%0d", j), a_run, 0);
            chk($sformatf("rst_pix_en%0d", j), a_pix, 0);
`ifdef CPU_CYCLE_COUNT_EN
            chk($sformatf("rst_cycle_count%0d", j), a_cc, 0);
`endif
         end else begin
            pulse = bh[2] && !bh[3];
            hm    = (mode == 2'b00 || mode == 2'b11);
            pix   = ((mt + 1) % (longint'(1) << PIX)) == 0;
            tk    = m_tick(mt, div_sel, cw[j]);
            nxt   = mst[j];
            en[j] = 1'b0;
            case (mst[j])
               0: begin
                  if (mode == 2'b01 && !halt_req) nxt = 1;
                  else if (mode == 2'b10 && pulse) nxt = 2;
               end
               1: begin
                  if (mode != 2'b01 || halt_req) nxt = 0;
                  else en[j] = tk;
               end
               default: begin
                  if (hm) nxt = 0;
                  else begin
                     en[j] = tk;
                     if (tk) nxt = 0;
                  end
               end
            endcase
            chk($sformatf("cpu_en%0d", j), a_en, int'(en[j]));
            chk($sformatf("running%0d", j), a_run, (mst[j] == 1) ? 1 : 0);
            chk($sformatf("pix_en%0d", j), a_pix, int'(pix));
`ifdef CPU_CYCLE_COUNT_EN
            chk($sformatf("cycle_count%0d", j), a_cc, mcc[j]);
`endif
            mst[j] = nxt;
            mcc[j] = mcc[j] + int'(en[j]);
         end
      end
      if (reset) begin
         mt = 0;
         mst = '{0, 0};
         bh = '{0, 0, 0, 0};
         mcc = '{0, 0};
      end else begin
         mt++;
         bh[3] = bh[2]; bh[2] = bh[1]; bh[1] = bh[0]; bh[0] = step_btn;
      end
   end

   int cnt_en, cnt_en_s, cnt_pix, cnt_run, first_en;

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   // n cycles starting now; step_btn follows pat[i]; counts sampled mid-cycle.
   task automatic win(input int n, input logic [15:0] pat);
      cnt_en = 0; cnt_en_s = 0; cnt_pix = 0; cnt_run = 0; first_en = -1;
      for (int i = 0; i < n; i++) begin
         step_btn = (i < 16) ? pat[i] : 1'b0;
         #3;
         if (cpu_en) begin
            cnt_en++;
            if (first_en < 0) first_en = i;
         end
         cnt_en_s += int'(cpu_en_s);
         cnt_pix  += int'(pix_en);
         cnt_run  += int'(running);
         next_cyc();
      end
      step_btn = 1'b0;
   endtask

   task automatic wait_tick(input int period);
      int tries;
      tries = 0;
      while (((mt + 1) % period) != 0 && tries < 1000) begin
         next_cyc();
         tries++;
      end
      if (tries >= 1000) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_tick: no tick of period %0d within 1000 cycles", period);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #3;
      chk("post_reset_running", int'(running), 0);
      chk("post_reset_cpu_en", int'(cpu_en), 0);
      next_cyc();

      // RUN at the fastest rate
      mode = 2'b01; div_sel = 5'd0;
      next_cyc();
      win(16, 16'h0000);
      chk("run_div0_cpu_en", cnt_en, 8);
      chk("run_div0_pix_en", cnt_pix, 4);
      chk("run_div0_running", cnt_run, 16);
      chk("run_div0_cpu_en_small", cnt_en_s, 8);

      // halt_req on a tick cycle suppresses that pulse
      div_sel = 5'd3;
      wait_tick(16);
      halt_req = 1'b1;
      #3;
      chk("halt_tick_cpu_en", int'(cpu_en), 0);
      chk("halt_tick_running", int'(running), 1);
      next_cyc();
      halt_req = 1'b0; mode = 2'b00;
      #3;
      chk("halted_running", int'(running), 0);
      next_cyc();

      // mode 11 behaves as HALT
      mode = 2'b01;
      next_cyc(); next_cyc();
      mode = 2'b11;
      #3;
      chk("mode3_cpu_en", int'(cpu_en), 0);
      next_cyc();
      #3;
      chk("mode3_running", int'(running), 0);
      mode = 2'b00;
      next_cyc();

      // single step: press on a tick cycle, pulse at +3, fire at +8
      mode = 2'b10; div_sel = 5'd2;
      next_cyc(); next_cyc();
      wait_tick(8);
      win(30, 16'h001F);
      chk("step_count", cnt_en, 1);
      chk("step_first", first_en, 8);
      chk("step_running", cnt_run, 0);

      // two presses 2 cycles apart: the second lands in STEP_WAIT
      wait_tick(8);
      win(30, 16'h0005);
      chk("dbl_step_count", cnt_en, 1);
      chk("dbl_step_first", first_en, 8);

      // clamped div_sel, then reset in the middle of a step
      div_sel = 5'd31;
      win(4, 16'h0000);
      win(12, 16'h0001);
      chk("clamp_step_pending", cnt_en, 0);
      reset = 1'b1;
      #3;
      chk("reset_mid_step_cpu_en", int'(cpu_en), 0);
      next_cyc(); next_cyc();
      reset = 1'b0; div_sel = 5'd0;
      win(8, 16'h0000);
      chk("after_reset_no_step", cnt_en, 0);
      chk("after_reset_no_step_small", cnt_en_s, 0);

      // long RUN with div_sel=31: 24-bit never ticks, 8-bit ticks every 256
      mode = 2'b01; div_sel = 5'd31;
      next_cyc();
      win(600, 16'h0000);
      chk("clamp_big_cpu_en", cnt_en, 0);
      chk("clamp_small_count", (cnt_en_s >= 2 && cnt_en_s <= 3) ? 1 : 0, 1);

      // div_sel changes mid-run without touching cnt
      div_sel = 5'd1;
      win(12, 16'h0000);
      chk("div1_cpu_en", cnt_en, 3);
      div_sel = 5'd0;
      win(8, 16'h0000);
      chk("div0_again_cpu_en", cnt_en, 4);

      // halt_req held blocks HALT -> RUN
      mode = 2'b00;
      next_cyc();
      halt_req = 1'b1; mode = 2'b01;
      win(6, 16'h0000);
      chk("halt_req_block_run", cnt_run, 0);
      chk("halt_req_block_en", cnt_en, 0);
      halt_req = 1'b0;

`ifdef CPU_CYCLE_COUNT_EN
      reset = 1'b1;
      next_cyc();
      reset = 1'b0; mode = 2'b01; div_sel = 5'd0;
      #3;
      chk("cc_after_reset", int'(cycle_count), 0);
      next_cyc();
      win(20, 16'h0000);
      chk("cc_window_en", cnt_en, 10);
      chk("cc_ten", int'(cycle_count), 10);
      reset = 1'b1;
      next_cyc();
      chk("cc_cleared", int'(cycle_count), 0);
      reset = 1'b0;
`endif

      mode = 2'b00;
      win(4, 16'h0000);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
